// File: rtl/ifetch_pkg.sv
// ifetch_pkg
// Shared types, opcode constants and helpers for the instruction fetch unit.
//   XLEN        - datapath / address width
//   OPC_RTYPE   - R-type opcode, instr[31:26]
//   OPC_JUMP    - J-type opcode, instr[31:26]
//   fetch_state_t - fetch-side FSM encoding
//   jump_target - J-type destination: {pc_plus4[31:28], instr[25:0], 2'b00}
package ifetch_pkg;

    localparam int XLEN = 32;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_JUMP  = 6'b000010;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_t;

    function automatic logic [XLEN-1:0] jump_target(input logic [XLEN-1:0] pc_plus4,
                                                    input logic [XLEN-1:0] instr);
        return {pc_plus4[31:28], instr[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_buf.sv
// ifetch_buf
// Synchronous FIFO of {instr, pc} with flush, occupancy count and a registered
// head. The head registers keep their last value when the FIFO empties.
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   flush                 - empty the FIFO; wins over same-cycle push/pop
//   push, push_instr/pc   - write one entry (ignored when full without a pop)
//   pop                   - retire the head entry (ignored when empty)
//   count                 - occupied entries, 0..DEPTH
//   head_valid            - FIFO non-empty
//   head_instr, head_pc   - registered head entry
module ifetch_buf
    import ifetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    push,
    input  logic [XLEN-1:0]         push_instr,
    input  logic [XLEN-1:0]         push_pc,
    input  logic                    pop,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    head_valid,
    output logic [XLEN-1:0]         head_instr,
    output logic [XLEN-1:0]         head_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] mem_instr [DEPTH];
    logic [XLEN-1:0] mem_pc    [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr, rd_next;
    logic [CW-1:0]   remain, count_next;
    logic            pop_ok, push_ok;

    always_comb begin
        pop_ok     = pop && (count != '0);
        push_ok    = push && ((count != CW'(DEPTH)) || pop_ok);
        remain     = count - CW'(pop_ok);
        count_next = remain + CW'(push_ok);
        rd_next    = rd_ptr + PW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem_instr[wr_ptr] <= push_instr;
            mem_pc[wr_ptr]    <= push_pc;
        end
    end

    // The head register is loaded with whatever will be at the front after
    // this cycle: an older stored entry if one survives the pop, otherwise
    // the word being pushed right now.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_instr <= '0;
            head_pc    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr <= rd_next;
            count  <= count_next;
            if (remain != '0) begin
                head_instr <= mem_instr[rd_next];
                head_pc    <= mem_pc[rd_next];
            end else if (push_ok) begin
                head_instr <= push_instr;
                head_pc    <= push_pc;
            end
        end
    end

    assign head_valid = (count != '0);

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch
// Instruction fetch unit: holds the PC, issues single-outstanding word reads
// to instruction memory, buffers returned words with their PCs and hands them
// to decode. Redirects flush the buffer and drop any in-flight word.
// Optional feature macro: IFETCH_JUMP_PREDECODE_EN (follow J-type words
// locally instead of fetching sequentially past them).
// Ports:
//   clk, rst_n              - clock, async active-low reset
//   imem_req/addr           - read request, held until imem_ack
//   imem_ack/rdata          - request accepted, word valid this cycle
//   instr_valid/ready       - decode handshake
//   instr, instr_pc         - head instruction and its address
//   redirect, redirect_pc   - one-cycle jump/branch request, new fetch address
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no request outstanding (buffer full or just drained)
// S_REQ   | request outstanding for imem_addr; ack delivers a wanted word
// S_DRAIN | request outstanding but redirected away; its ack is dropped
module instr_fetch
    import ifetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [XLEN-1:0]  imem_rdata,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [XLEN-1:0]  instr,
    output logic [XLEN-1:0]  instr_pc,
    input  logic             redirect,
    input  logic [XLEN-1:0]  redirect_pc
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] pc_plus4, pc_adv, redirect_pc_al;
    logic [CW-1:0]   buf_count, occ_next;
    logic            push, pop, space;

    assign redirect_pc_al = redirect_pc & ~32'h0000_0003;
    assign pc_plus4       = pc_q + 32'd4;

`ifdef IFETCH_JUMP_PREDECODE_EN
    assign pc_adv = (imem_rdata[31:26] == OPC_JUMP) ? jump_target(pc_plus4, imem_rdata)
                                                     : pc_plus4;
`else
    assign pc_adv = pc_plus4;
`endif

    assign pop  = instr_valid && instr_ready;
    assign push = imem_ack && (state_q == S_REQ) && !redirect;

    // Occupancy after this edge; counting the same-cycle pop lets a depth-2
    // buffer sustain one instruction per cycle.
    assign occ_next = buf_count - CW'(pop) + CW'(push);
    assign space    = occ_next < CW'(BUF_DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                if (redirect) begin
                    pc_d    = redirect_pc_al;
                    addr_d  = redirect_pc_al;
                    state_d = S_REQ;
                end else if (space) begin
                    addr_d  = pc_q;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (redirect) begin
                    pc_d = redirect_pc_al;
                    if (imem_ack) begin
                        // word dropped; nothing left in flight, restart at once
                        addr_d = redirect_pc_al;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (imem_ack) begin
                    pc_d = pc_adv;
                    if (space) begin
                        addr_d = pc_adv;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (redirect) begin
                    pc_d = redirect_pc_al;
                end
                if (imem_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign imem_req  = (state_q != S_IDLE);
    assign imem_addr = addr_q;

    ifetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect),
        .push       (push),
        .push_instr (imem_rdata),
        .push_pc    (pc_q),
        .pop        (pop),
        .count      (buf_count),
        .head_valid (instr_valid),
        .head_instr (instr),
        .head_pc    (instr_pc)
    );

endmodule
